// File: rtl/usb_wr_pkg.sv
// Shared state encoding and default widths for the USB write-path framer.
// No logic here; there is no latency and no backpressure involved.
package usb_wr_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SYNC_WORD_DEFAULT = 16'hA55A;

  typedef enum logic [2:0] {
    HUNT,
    ADDR_HI,
    ADDR_LO,
    LEN,
    DATA,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/usb_wr_outreg.sv
// Single-entry write-request register: 1 clk from load to wr_valid.
// Holds addr/data stable while wr_ready is low; can_load permits retire-and-reload on one edge.
module usb_wr_outreg #(
  parameter int ADDR_W = usb_wr_pkg::ADDR_W,
  parameter int DATA_W = usb_wr_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_vld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              can_load,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready
);

  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (ld_vld) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = ld_addr;
      wr_data_d  = ld_data;
    end else if (wr_ready) begin
      wr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign can_load = !wr_valid_q || wr_ready;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: rtl/usb_wr_framer.sv
// Frames sync/addr/len/payload words into SDRAM writes, 1 clk ingress-to-wr_valid, 1 word/clk sustained.
// s_ready drops while a write is stalled; USB_WR_FRAMER_CHECKSUM_EN adds a trailing XOR checksum word.
module usb_wr_framer #(
  parameter int                ADDR_W    = usb_wr_pkg::ADDR_W,
  parameter int                DATA_W    = usb_wr_pkg::DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD = usb_wr_pkg::SYNC_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  import usb_wr_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
`ifdef USB_WR_FRAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif
  logic              ld_vld;
  logic              can_load;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
`ifdef USB_WR_FRAMER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    ld_vld     = 1'b0;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    // Reset suppresses every handshake and pulse in the reset cycle itself.
    if (!rst) begin
      case (state_q)
        HUNT: begin
          s_ready = 1'b1;
          if (s_valid && s_data == SYNC_WORD) state_d = ADDR_HI;
        end
        ADDR_HI: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (s_data[DATA_W-1:8] != '0) begin
              frame_err = 1'b1;
              state_d   = HUNT;
            end else begin
              addr_d[ADDR_W-1:16] = s_data[ADDR_W-17:0];
              state_d             = ADDR_LO;
            end
          end
        end
        ADDR_LO: begin
          s_ready = 1'b1;
          if (s_valid) begin
            addr_d[15:0] = s_data[15:0];
            state_d      = LEN;
          end
        end
        LEN: begin
          s_ready = 1'b1;
          if (s_valid) begin
            rem_d = s_data;
`ifdef USB_WR_FRAMER_CHECKSUM_EN
            csum_d = '0;
`endif
            if (s_data == '0) begin
              frame_err = 1'b1;
              state_d   = HUNT;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          s_ready = can_load;
          if (s_valid && can_load) begin
            ld_vld = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - DATA_W'(1);
`ifdef USB_WR_FRAMER_CHECKSUM_EN
            csum_d = csum_q ^ s_data;
            if (rem_q == DATA_W'(1)) state_d = CSUM;
`else
            if (rem_q == DATA_W'(1)) state_d = DONE;
`endif
          end
        end
`ifdef USB_WR_FRAMER_CHECKSUM_EN
        CSUM: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (s_data != csum_q) begin
              frame_err = 1'b1;
              state_d   = HUNT;
            end else if (!wr_valid || wr_ready) begin
              // Last write retires now (or already has), so the frame ends here.
              frame_done = 1'b1;
              state_d    = HUNT;
            end else begin
              state_d = DONE;
            end
          end
        end
`endif
        DONE: begin
          if (wr_valid && wr_ready) begin
            frame_done = 1'b1;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      addr_q  <= '0;
      rem_q   <= '0;
`ifdef USB_WR_FRAMER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
`ifdef USB_WR_FRAMER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy = (state_q != HUNT);

  usb_wr_outreg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .ld_vld  (ld_vld),
    .ld_addr (addr_q),
    .ld_data (s_data),
    .can_load(can_load),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready)
  );

endmodule
